// File: rtl/alu_sequencer.sv
// ALU operation sequencer: accepts one request, feeds operand A then B to an
// external ALU over a shared bus, enables the ALU result in EXEC, captures
// it, and holds it in RESP until the consumer accepts it.
module alu_sequencer #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              async_reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    output logic [DATA_W-1:0] bus_out,
    output logic              bus_drive,
    output logic [2:0]        alu_en,
    output logic [3:0]        alu_func,
    input  logic [DATA_W-1:0] alu_result,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              busy,
    output logic [7:0]        ops_count
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_A = 3'd1,
        LOAD_B = 3'd2,
        EXEC   = 3'd3,
        RESP   = 3'd4
    } state_t;

    state_t            state;
    logic [1:0]        op_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic [7:0]        ops_count_q;

    // State machine, operand latch, result capture and completion counter
    always_ff @(posedge clk or negedge async_reset_n) begin
        if (!async_reset_n) begin
            state       <= IDLE;
            op_q        <= 2'b00;
            a_q         <= '0;
            b_q         <= '0;
            rsp_data_q  <= '0;
            ops_count_q <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        op_q  <= req_op;
                        a_q   <= req_a;
                        b_q   <= req_b;
                        state <= LOAD_A;
                    end
                end
                LOAD_A: state <= LOAD_B;
                LOAD_B: state <= EXEC;
                EXEC: begin
                    // Raw sample: overflow/borrow already wrapped by the ALU
                    rsp_data_q <= alu_result;
                    state      <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        ops_count_q <= ops_count_q + 8'd1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs decode from state only, so none depend on req_valid/rsp_ready
    always_comb begin
        req_ready = 1'b0;
        busy      = 1'b1;
        bus_drive = 1'b0;
        bus_out   = '0;
        alu_en    = 3'b000;
        alu_func  = 4'b0000;
        rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
            end
            LOAD_A: begin
                bus_drive = 1'b1;
                bus_out   = a_q;
                alu_en    = 3'b001;
                alu_func  = {2'b00, op_q};
            end
            LOAD_B: begin
                bus_drive = 1'b1;
                bus_out   = b_q;
                alu_en    = 3'b010;
                alu_func  = {2'b00, op_q};
            end
            EXEC: begin
                alu_en   = 3'b100;
                alu_func = {2'b00, op_q};
            end
            RESP: rsp_valid = 1'b1;
            default: busy = 1'b1;
        endcase
    end

    assign rsp_data  = rsp_data_q;
    assign ops_count = ops_count_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: a behavioural ALU on the bus side, a cycle-phase
// reference model checked every cycle, and directed literal expectations.
module tb_alu_sequencer;

    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              async_reset_n;
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_op;
    logic [DATA_W-1:0] req_a;
    logic [DATA_W-1:0] req_b;
    logic [DATA_W-1:0] bus_out;
    logic              bus_drive;
    logic [2:0]        alu_en;
    logic [3:0]        alu_func;
    logic [DATA_W-1:0] alu_result;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              busy;
    logic [7:0]        ops_count;

    int errors = 0;
    int checks = 0;

    alu_sequencer #(.DATA_W(DATA_W)) dut (
        .clk(clk), .async_reset_n(async_reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .bus_out(bus_out), .bus_drive(bus_drive),
        .alu_en(alu_en), .alu_func(alu_func), .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .busy(busy), .ops_count(ops_count)
    );

    always #5 clk = ~clk;

    // Simple ALU: operand registers loaded from the bus, combinational result
    logic [DATA_W-1:0] alu_ra, alu_rb;
    always @(posedge clk) begin
        if (alu_en[0]) alu_ra <= bus_out;
        if (alu_en[1]) alu_rb <= bus_out;
    end
    always_comb begin
        case (alu_func[1:0])
            2'b01:   alu_result = alu_ra + alu_rb;
            2'b10:   alu_result = alu_ra - alu_rb;
            2'b11:   alu_result = alu_ra ^ alu_rb;
            default: alu_result = '0;
        endcase
    end

    function automatic logic [DATA_W-1:0] calc(input logic [1:0] op,
                                               input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
        case (op)
            2'b01:   return a + b;
            2'b10:   return a - b;
            2'b11:   return a ^ b;
            default: return '0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase = cycles into the operation (0 idle, 4 response)
    int                m_phase = 0;
    logic [1:0]        m_op = 0;
    logic [DATA_W-1:0] m_a = 0, m_b = 0, m_rsp = 0;
    logic [7:0]        m_cnt = 0;

    always @(posedge clk or negedge async_reset_n) begin
        if (!async_reset_n) begin
            m_phase = 0; m_op = 0; m_a = 0; m_b = 0; m_rsp = 0; m_cnt = 0;
        end else if (m_phase == 0) begin
            if (req_valid) begin
                m_op = req_op; m_a = req_a; m_b = req_b; m_phase = 1;
            end
        end else if (m_phase == 3) begin
            m_rsp   = calc(m_op, m_a, m_b);
            m_phase = 4;
        end else if (m_phase == 4) begin
            if (rsp_ready) begin
                m_cnt   = m_cnt + 8'd1;
                m_phase = 0;
            end
        end else begin
            m_phase = m_phase + 1;
        end
    end

    // Per-cycle compare against the model plus bus/enable invariants
    always @(negedge clk) begin
        chk("req_ready", req_ready, m_phase == 0);
        chk("busy", busy, m_phase != 0);
        chk("bus_drive", bus_drive, m_phase == 1 || m_phase == 2);
        chk("bus_out", bus_out, m_phase == 1 ? m_a : m_phase == 2 ? m_b : '0);
        chk("alu_en", alu_en, m_phase == 1 ? 3'b001 : m_phase == 2 ? 3'b010 :
                              m_phase == 3 ? 3'b100 : 3'b000);
        chk("alu_func", alu_func, (m_phase >= 1 && m_phase <= 3) ? {2'b00, m_op} : 4'b0000);
        chk("rsp_valid", rsp_valid, m_phase == 4);
        chk("rsp_data", rsp_data, m_rsp);
        chk("ops_count", ops_count, m_cnt);
        chk("drive_vs_en2", bus_drive & alu_en[2], 1'b0);
        chk("alu_en_onehot0", $onehot0(alu_en), 1'b1);
    end

    task automatic issue(input logic [1:0] op, input logic [DATA_W-1:0] a,
                         input logic [DATA_W-1:0] b);
        int n = 0;
        while (!req_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk("ready_timeout", req_ready, 1'b1);
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    // Runs one op with rsp_ready=1; lit enables the per-phase literal checks
    task automatic run_op(input logic [1:0] op, input logic [DATA_W-1:0] a,
                          input logic [DATA_W-1:0] b, input logic [DATA_W-1:0] exp,
                          input bit lit);
        rsp_ready = 1'b1;
        issue(op, a, b);
        if (lit) begin
            chk("lA_bus_out", bus_out, a);
            chk("lA_en", alu_en, 3'b001);
        end
        @(posedge clk); #1;
        if (lit) begin
            chk("lB_bus_out", bus_out, b);
            chk("lB_en", alu_en, 3'b010);
        end
        @(posedge clk); #1;
        if (lit) begin
            chk("ex_en", alu_en, 3'b100);
            chk("ex_func", alu_func, {2'b00, op});
            chk("ex_drive", bus_drive, 1'b0);
        end
        @(posedge clk); #1;
        chk("rsp_valid_lat3", rsp_valid, 1'b1);
        chk("rsp_data_exp", rsp_data, exp);
        @(posedge clk); #1;
    endtask

    initial begin
        async_reset_n = 1'b0;
        req_valid = 1'b0; req_op = 2'b00; req_a = '0; req_b = '0;
        rsp_ready = 1'b1;
        #12;
        chk("rst_req_ready", req_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_rsp_data", rsp_data, 8'h00);
        chk("rst_ops_count", ops_count, 8'h00);
        @(posedge clk); #1;
        async_reset_n = 1'b1;

        run_op(2'b01, 8'h25, 8'h17, 8'h3C, 1'b1);
        chk("add_count", ops_count, 8'd1);
        run_op(2'b10, 8'h05, 8'h0A, 8'hFB, 1'b1);
        run_op(2'b11, 8'hF0, 8'hFF, 8'h0F, 1'b1);
        run_op(2'b00, 8'h99, 8'h66, 8'h00, 1'b1);
        chk("count4", ops_count, 8'd4);

        // Backpressure with a competing request held high
        rsp_ready = 1'b0;
        issue(2'b01, 8'h40, 8'h02);
        repeat (3) begin @(posedge clk); #1; end
        req_valid = 1'b1; req_op = 2'b11; req_a = 8'hAA; req_b = 8'h55;
        repeat (6) begin
            chk("bp_valid", rsp_valid, 1'b1);
            chk("bp_data", rsp_data, 8'h42);
            chk("bp_ready", req_ready, 1'b0);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("bp_idle", busy, 1'b0);
        chk("bp_count", ops_count, 8'd5);

        // Reset mid-operation during LOAD_B
        issue(2'b01, 8'h11, 8'h22);
        @(posedge clk); #1;
        chk("rstB_pre", bus_out, 8'h22);
        async_reset_n = 1'b0;
        #1;
        chk("rstB_bus_out", bus_out, 8'h00);
        chk("rstB_drive", bus_drive, 1'b0);
        chk("rstB_en", alu_en, 3'b000);
        chk("rstB_busy", busy, 1'b0);
        chk("rstB_count", ops_count, 8'd0);
        chk("rstB_rsp_data", rsp_data, 8'h00);
        repeat (2) begin @(posedge clk); #1; chk("rstB_no_rsp", rsp_valid, 1'b0); end
        async_reset_n = 1'b1;
        run_op(2'b01, 8'h01, 8'h02, 8'h03, 1'b0);
        chk("post_rst_count", ops_count, 8'd1);

        // Back-to-back ops: 255 more wraps to 0, one more gives 1
        for (int i = 0; i < 256; i++) begin
            logic [1:0] op;
            logic [DATA_W-1:0] a, b;
            op = 2'($urandom_range(0, 3));
            a  = 8'($urandom);
            b  = 8'($urandom);
            run_op(op, a, b, calc(op, a, b), 1'b0);
            if (i == 254) chk("wrap_zero", ops_count, 8'd0);
        end
        chk("wrap_one", ops_count, 8'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter: DATA_W, default 8, width of operands, bus and result.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-003 Port: clk  in  1  rising-edge clock.
REQ-004 Port: async_reset_n  in  1  asynchronous active-low reset.
REQ-005 Port: req_valid  in  1  operation request valid.
REQ-006 Port: req_ready  out  1  sequencer can accept a request.
REQ-007 Port: req_op  in  2  00 zero, 01 add, 10 sub, 11 xor.
REQ-008 Port: req_a  in  DATA_W  operand A.
REQ-009 Port: req_b  in  DATA_W  operand B.
REQ-010 Port: bus_out  out  DATA_W  value the sequencer drives onto the shared bus.
REQ-011 Port: bus_drive  out  1  sequencer owns the bus this cycle.
REQ-012 Port: alu_en  out  3  ALU enables: [0] load A, [1] load B, [2] drive result.
REQ-013 Port: alu_func  out  4  ALU function select.
REQ-014 Port: alu_result  in  DATA_W  ALU result bus, sampled by the sequencer.
REQ-015 Port: rsp_valid  out  1  result available.
REQ-016 Port: rsp_ready  in  1  consumer accepts result.
REQ-017 Port: rsp_data  out  DATA_W  captured result.
REQ-018 Port: busy  out  1  high in any state other than IDLE.
REQ-019 Port: ops_count  out  8  completed-operation counter.

Function
REQ-020 FSM states SHALL be IDLE, LOAD_A, LOAD_B, EXEC, RESP; every transition occurs on a rising clk edge.
REQ-021 req_ready SHALL be 1 only in IDLE; a request is accepted on an edge where req_valid && req_ready.
REQ-022 On accept, op, req_a and req_b SHALL be latched internally; the FSM goes IDLE -> LOAD_A. Request inputs are ignored in all other states.
REQ-023 LOAD_A: bus_drive=1, bus_out=latched A, alu_en=3'b001; the FSM goes unconditionally to LOAD_B.
REQ-024 LOAD_B: bus_drive=1, bus_out=latched B, alu_en=3'b010; the FSM goes unconditionally to EXEC.
REQ-025 EXEC: bus_drive=0, alu_en=3'b100; rsp_data SHALL capture alu_result at the exiting edge; the FSM goes to RESP.
REQ-026 alu_func SHALL be {2'b00, op} from LOAD_A through EXEC, and 4'b0000 otherwise.
REQ-027 RESP: rsp_valid=1, and rsp_data is held stable; when rsp_ready=1 the FSM goes to IDLE, otherwise it stays in RESP.
REQ-028 Latency: rsp_valid SHALL rise exactly 3 edges after the accepting edge; minimum spacing between accepts is 5 cycles.
REQ-029 Outside LOAD_A/LOAD_B, bus_drive=0 and bus_out=0; outside LOAD_A/LOAD_B/EXEC, alu_en=3'b000.
REQ-030 bus_drive and alu_en[2] SHALL never both be 1, and alu_en SHALL be zero or one-hot.
REQ-031 op=00 SHALL run the full sequence, and rsp_data equals the sampled alu_result (0 from a conforming ALU).
REQ-032 ops_count SHALL increment by 1 on each edge where rsp_valid && rsp_ready, and wraps 255 -> 0.
REQ-033 rsp_data SHALL be the raw DATA_W-bit sample; the sequencer performs no arithmetic on it (overflow and borrow wrap in the ALU).
REQ-034 outputs are combinational decodes of state only; no output depends combinationally on req_valid or rsp_ready.

Reset
REQ-035 async_reset_n=0 SHALL immediately force IDLE with req_ready=1 and these values at 0: busy, rsp_valid, rsp_data, bus_drive, bus_out, alu_en, alu_func, ops_count, latched operands.
REQ-036 Reset asserted in any state, including mid-operation, SHALL drop the in-flight operation with no response, and ops_count SHALL not increment.
REQ-037 Deassertion is synchronous to clk; the first accept is possible on the first edge after release.

Verification
REQ-038 Add A=8'h25 B=8'h17 op=01, rsp_ready=1 -> LOAD_A bus_out=25 en=001, LOAD_B bus_out=17 en=010, EXEC en=100 func=0001, rsp_data=8'h3C 3 edges after accept, ops_count=1.
REQ-039 Sub A=8'h05 B=8'h0A op=10 -> rsp_data=8'hFB; xor A=8'hF0 B=8'hFF op=11 -> rsp_data=8'h0F.
REQ-040 Backpressure: rsp_ready=0 for 6 cycles after rsp_valid -> rsp_valid and rsp_data held, req_ready=0, new req_valid ignored; rsp_ready=1 -> IDLE next edge.
REQ-041 Reset pulse during LOAD_B -> outputs zero immediately, no rsp_valid, ops_count unchanged at 0, next request completes normally.
REQ-042 256 back-to-back ops with rsp_ready=1 -> ops_count wraps to 0; throughout, bus_drive && alu_en[2] is never 1 and alu_en is never multi-hot.
